mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between two requesters:
  - port 0: the multicycle control unit/datapath (instruction fetch and lw/sw);
  - port 1: the crypto engine's block load/store unit.
- Each requester uses a level-held read/write strobe and waits for a done pulse, the same handshake the control unit already uses.
- The arbiter registers the winning transaction, drives memory, captures read data and returns done to the owner only.
- Arbitration is round-robin, and a grant is held until the transaction completes.

Parameters:
AW, 32, address width
DW, 32, data width

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-high reset
m0_read  in  1  port 0 read request, held until m0_done
m0_write  in  1  port 0 write request, held until m0_done
m0_addr  in  AW  port 0 address
m0_wdata  in  DW  port 0 write data
m0_done  out  1  port 0 completion pulse, one cycle
m1_read, m1_write, m1_addr, m1_wdata, m1_done  same as port 0, for port 1
rdata  out  DW  read data for the current owner, valid while mX_done=1
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
mem_addr  out  AW  memory address (registered)
mem_wdata  out  DW  memory write data (registered)
mem_rdata  in  DW  memory read data, valid with mem_done
mem_done  in  1  memory completion, may take any number of cycles
owner  out  1  port currently or last granted

Behaviour:
Reset (sync):
- state=IDLE, last=1 (port 0 wins the first tie), owner=0.
- mem_read, mem_write, m0_done, m1_done all 0; mem_addr, mem_wdata, rdata all 0.
- Reset mid-transaction: strobes drop at the reset edge and no done is issued.

States: IDLE, ACCESS, RESP.

IDLE:
- reqX = mX_read | mX_write.
- Only one req: grant it. Both: grant the port != last. Neither: stay in IDLE.
- On grant (edge N):
  - latch mem_addr and mem_wdata from the winner;
  - mem_read=winner read, mem_write=winner write & ~winner read (read wins if both are set);
  - set owner and last to the winner; go to ACCESS.
- The memory strobe is therefore visible in cycle N+1: one cycle of arbitration latency.

ACCESS:
- Strobes held constant until mem_done=1.
- On the mem_done edge:
  - strobes go to 0;
  - rdata<=mem_rdata for reads; rdata is unchanged for writes;
  - the owner's mX_done<=1; go to RESP.
- Requester inputs are ignored in ACCESS, because address and data are latched at grant.
- A requester dropping its request mid-access does not abort: the access completes and done is still issued.

RESP:
- The owner's mX_done is 1 for exactly one cycle; then mX_done<=0 and return to IDLE.
- Requests are not sampled in RESP. The owner deasserts on seeing done, so a stale request is never re-granted.
- The other port's pending request is granted at the next IDLE edge.
- Back-to-back from the same port alone: IDLE→ACCESS→RESP repeats, minimum 3 cycles per transaction with zero-wait memory.

Other rules:
- mem_done outside ACCESS is ignored.
- The non-owner's done is never asserted.
- Fairness: with both ports continuously requesting, grants strictly alternate 0,1,0,1.

Decomposition:
- Shared package (mem_arb_pkg):
  - state encodings IDLE/ACCESS/RESP (2-bit);
  - port ID constants PORT_CPU=0, PORT_CRYPTO=1.
- One natural sub-module, rr_pick2: combinational winner select from req0, req1 and last. The last register stays in the parent.
- Datapath latches (address, write data, read data) stay in the parent.

Test Plan:
- Single read, port 0, addr 0x40, mem_done 2 cycles after mem_read → mem_read in cycle 1; m0_done one cycle with rdata=mem_rdata (0xDEADBEEF); m1_done stays 0.
- Simultaneous m0_write (0x10, 0x1) and m1_read (0x20) after reset → port 0 served first (mem_write, addr 0x10), then port 1 (mem_read, addr 0x20); owner 0→1.
- Both ports hold requests for 6 transactions, zero-wait memory → grant order 0,1,0,1,0,1; each transaction 3 cycles.
- Port 1 changes m1_addr from 0x30 to 0x99 during ACCESS → mem_addr stays 0x30; done still issued.
- rst=1 mid-ACCESS → next edge: mem_read=0, no done, state IDLE; a later mem_done pulse is ignored.
- Zero-wait memory (mem_done=1 always) with m0_read held through RESP → exactly one transaction per handshake, no duplicate grant.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encodings
// and requester port identifiers.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic PORT_CPU    = 1'b0;
  localparam logic PORT_CRYPTO = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the external memory port around the arbiter.
// slave = arbiter side, master = requesters plus memory model side.
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_read;
  logic          m0_write;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata;
  logic          m0_done;

  logic          m1_read;
  logic          m1_write;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata;
  logic          m1_done;

  logic [DW-1:0] rdata;
  logic          owner;

  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          mem_done;

  modport slave (
    input  m0_read, m0_write, m0_addr, m0_wdata,
    input  m1_read, m1_write, m1_addr, m1_wdata,
    input  mem_rdata, mem_done,
    output m0_done, m1_done, rdata, owner,
    output mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output m0_read, m0_write, m0_addr, m0_wdata,
    output m1_read, m1_write, m1_addr, m1_wdata,
    output mem_rdata, mem_done,
    input  m0_done, m1_done, rdata, owner,
    input  mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin winner select; the port that did not win last time
// takes a tie. Purely combinational, the last-grant register lives in the parent.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic gnt_vld,
  output logic gnt_id
);
  always_comb begin
    gnt_vld = req0 | req1;
    if (req0 && req1) gnt_id = ~last;
    else              gnt_id = req1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the CPU (port 0) and the crypto
// engine (port 1); grants are held for a whole transaction.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
);

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          mem_read_q, mem_read_d;
  logic          mem_write_q, mem_write_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          m0_done_q, m0_done_d;
  logic          m1_done_q, m1_done_d;

  logic req0, req1, gnt_vld, gnt_id;
  logic win_read, win_write;

  assign req0 = bus.m0_read | bus.m0_write;
  assign req1 = bus.m1_read | bus.m1_write;

  rr_pick2 u_pick (
    .req0    (req0),
    .req1    (req1),
    .last    (last_q),
    .gnt_vld (gnt_vld),
    .gnt_id  (gnt_id)
  );

  assign win_read  = (gnt_id == PORT_CRYPTO) ? bus.m1_read  : bus.m0_read;
  assign win_write = (gnt_id == PORT_CRYPTO) ? bus.m1_write : bus.m0_write;

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    m0_done_d   = 1'b0;
    m1_done_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          mem_addr_d  = (gnt_id == PORT_CRYPTO) ? bus.m1_addr  : bus.m0_addr;
          mem_wdata_d = (gnt_id == PORT_CRYPTO) ? bus.m1_wdata : bus.m0_wdata;
          // A requester asserting both strobes gets a read.
          mem_read_d  = win_read;
          mem_write_d = win_write & ~win_read;
          owner_d     = gnt_id;
          last_d      = gnt_id;
          state_d     = ACCESS;
        end
      end
      ACCESS: begin
        if (bus.mem_done) begin
          mem_read_d  = 1'b0;
          mem_write_d = 1'b0;
          if (mem_read_q) rdata_d = bus.mem_rdata;
          if (owner_q == PORT_CRYPTO) m1_done_d = 1'b1;
          else                        m0_done_d = 1'b1;
          state_d = RESP;
        end
      end
      // Requests are not looked at here, so the owner's stale request
      // (still high while it sees done) cannot be re-granted.
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      m0_done_q   <= 1'b0;
      m1_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      m0_done_q   <= m0_done_d;
      m1_done_q   <= m1_done_d;
    end
  end

  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.m0_done   = m0_done_q;
  assign bus.m1_done   = m1_done_q;
  assign bus.owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a per-cycle vector table for the basic
// handshakes, then hand-written fairness, reset-abort and zero-wait sequences.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  typedef struct {
    logic        rst;
    logic        m0_read;
    logic        m0_write;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m1_read;
    logic        m1_write;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        e_rd;
    logic        e_wr;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [31:0] e_rdata;
    logic        e_d0;
    logic        e_d1;
    logic        e_own;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.m0_read   = 1'b0;
    bus.m0_write  = 1'b0;
    bus.m0_addr   = '0;
    bus.m0_wdata  = '0;
    bus.m1_read   = 1'b0;
    bus.m1_write  = 1'b0;
    bus.m1_addr   = '0;
    bus.m1_wdata  = '0;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  function automatic logic [127:0] pack_out();
    return {27'd0, bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wdata,
            bus.rdata, bus.m0_done, bus.m1_done, bus.owner};
  endfunction

  initial begin
    int   n;
    int   prev_cyc;
    logic prev_strobe;
    int   reads;
    int   dones;

    // rst m0r m0w m0a m0wd m1r m1w m1a m1wd md mrd | rd wr addr wdata rdata d0 d1 own
    tbl[0]  = '{1,0,0,32'h00,32'h0,0,0,32'h00,32'h0,0,32'h0,        0,0,32'h00,32'h0,32'h0,0,0,0};
    tbl[1]  = '{0,1,0,32'h40,32'h0,0,0,32'h00,32'h0,0,32'h0,        1,0,32'h40,32'h0,32'h0,0,0,0};
    tbl[2]  = '{0,1,0,32'h40,32'h0,0,0,32'h00,32'h0,0,32'h0,        1,0,32'h40,32'h0,32'h0,0,0,0};
    tbl[3]  = '{0,1,0,32'h40,32'h0,0,0,32'h00,32'h0,1,32'hDEADBEEF, 0,0,32'h40,32'h0,32'hDEADBEEF,1,0,0};
    tbl[4]  = '{0,0,0,32'h00,32'h0,0,0,32'h00,32'h0,0,32'h0,        0,0,32'h40,32'h0,32'hDEADBEEF,0,0,0};
    tbl[5]  = '{0,0,0,32'h00,32'h0,0,0,32'h00,32'h0,0,32'h0,        0,0,32'h40,32'h0,32'hDEADBEEF,0,0,0};
    tbl[6]  = '{1,0,0,32'h00,32'h0,0,0,32'h00,32'h0,0,32'h0,        0,0,32'h00,32'h0,32'h0,0,0,0};
    tbl[7]  = '{0,0,1,32'h10,32'h1,1,0,32'h20,32'h0,0,32'h0,        0,1,32'h10,32'h1,32'h0,0,0,0};
    tbl[8]  = '{0,0,1,32'h10,32'h1,1,0,32'h20,32'h0,1,32'h5555,     0,0,32'h10,32'h1,32'h0,1,0,0};
    tbl[9]  = '{0,0,0,32'h10,32'h1,1,0,32'h20,32'h0,0,32'h0,        0,0,32'h10,32'h1,32'h0,0,0,0};
    tbl[10] = '{0,0,0,32'h10,32'h1,1,0,32'h20,32'h0,0,32'h0,        1,0,32'h20,32'h0,32'h0,0,0,1};
    tbl[11] = '{0,0,0,32'h00,32'h0,1,0,32'h20,32'h0,1,32'hCAFEF00D, 0,0,32'h20,32'h0,32'hCAFEF00D,0,1,1};
    tbl[12] = '{0,0,0,32'h00,32'h0,0,0,32'h00,32'h0,0,32'h0,        0,0,32'h20,32'h0,32'hCAFEF00D,0,0,1};
    tbl[13] = '{0,0,0,32'h00,32'h0,1,0,32'h30,32'h0,0,32'h0,        1,0,32'h30,32'h0,32'hCAFEF00D,0,0,1};
    tbl[14] = '{0,0,0,32'h00,32'h0,1,0,32'h99,32'h0,0,32'h0,        1,0,32'h30,32'h0,32'hCAFEF00D,0,0,1};
    tbl[15] = '{0,0,0,32'h00,32'h0,1,0,32'h99,32'h0,1,32'h1234,     0,0,32'h30,32'h0,32'h1234,0,1,1};
    tbl[16] = '{0,0,0,32'h00,32'h0,0,0,32'h00,32'h0,0,32'h0,        0,0,32'h30,32'h0,32'h1234,0,0,1};
    tbl[17] = '{0,0,0,32'h00,32'h0,0,0,32'h00,32'h0,1,32'hFFFF,     0,0,32'h30,32'h0,32'h1234,0,0,1};
    tbl[18] = '{0,0,0,32'h00,32'h0,0,0,32'h00,32'h0,1,32'hFFFF,     0,0,32'h30,32'h0,32'h1234,0,0,1};

    clear_inputs();
    rst = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      rst           = tbl[i].rst;
      bus.m0_read   = tbl[i].m0_read;
      bus.m0_write  = tbl[i].m0_write;
      bus.m0_addr   = tbl[i].m0_addr;
      bus.m0_wdata  = tbl[i].m0_wdata;
      bus.m1_read   = tbl[i].m1_read;
      bus.m1_write  = tbl[i].m1_write;
      bus.m1_addr   = tbl[i].m1_addr;
      bus.m1_wdata  = tbl[i].m1_wdata;
      bus.mem_done  = tbl[i].mem_done;
      bus.mem_rdata = tbl[i].mem_rdata;
      tick();
      chk($sformatf("vec%0d", i), pack_out(),
          {27'd0, tbl[i].e_rd, tbl[i].e_wr, tbl[i].e_addr, tbl[i].e_wdata,
           tbl[i].e_rdata, tbl[i].e_d0, tbl[i].e_d1, tbl[i].e_own});
    end

    // Fairness: both ports request continuously, zero-wait memory.
    do_reset();
    bus.m0_read  = 1'b1;
    bus.m0_addr  = 32'h100;
    bus.m1_write = 1'b1;
    bus.m1_addr  = 32'h200;
    bus.m1_wdata = 32'hABCD;
    bus.mem_done = 1'b1;
    n = 0;
    prev_cyc = 0;
    prev_strobe = 1'b0;
    for (int c = 1; c <= 40 && n < 6; c++) begin
      tick();
      if ((bus.mem_read | bus.mem_write) && !prev_strobe) begin
        chk($sformatf("fair_owner%0d", n), {127'd0, bus.owner}, n % 2);
        chk($sformatf("fair_kind%0d", n), {94'd0, bus.mem_read, bus.mem_write, bus.mem_addr},
            (n % 2 == 0) ? {94'd0, 2'b10, 32'h100} : {94'd0, 2'b01, 32'h200});
        if (n > 0) chk($sformatf("fair_gap%0d", n), c - prev_cyc, 3);
        prev_cyc = c;
        n++;
      end
      prev_strobe = bus.mem_read | bus.mem_write;
    end
    chk("fair_count", n, 6);

    // Reset during ACCESS aborts without a done; a later mem_done is ignored.
    do_reset();
    bus.m0_read = 1'b1;
    bus.m0_addr = 32'h44;
    tick();
    chk("rstmid_access", {95'd0, bus.mem_read, bus.mem_addr}, {95'd0, 1'b1, 32'h44});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rstmid_abort", {124'd0, bus.mem_read, bus.m0_done, bus.m1_done, bus.owner}, 128'd0);
    bus.m0_read  = 1'b0;
    bus.mem_done = 1'b1;
    bus.mem_rdata = 32'h7777;
    tick();
    bus.mem_done = 1'b0;
    chk("rstmid_stray_done", {93'd0, bus.mem_read, bus.m0_done, bus.m1_done, bus.rdata},
        128'd0);
    tick();
    chk("rstmid_quiet", {125'd0, bus.mem_read, bus.m0_done, bus.m1_done}, 128'd0);

    // Zero-wait memory with m0_read held through RESP: one transaction only.
    do_reset();
    bus.mem_done  = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    bus.m0_read   = 1'b1;
    bus.m0_addr   = 32'h50;
    tick();
    chk("zw_grant", {95'd0, bus.mem_read, bus.mem_addr}, {95'd0, 1'b1, 32'h50});
    tick();
    chk("zw_done", {95'd0, bus.m0_done, bus.rdata}, {95'd0, 1'b1, 32'h0BADF00D});
    tick();
    chk("zw_resp_exit", {126'd0, bus.mem_read, bus.m0_done}, 128'd0);
    bus.m0_read = 1'b0;
    reads = 0;
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (bus.mem_read) reads++;
      if (bus.m0_done) dones++;
    end
    chk("zw_no_dup", {reads, dones}, 64'd0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
